// File: rtl/dm_unloader.sv
// dm_unloader: streams LEN consecutive data-memory words from BASE_ADDR onto a
// valid/ready output. A credit check against FIFO occupancy plus in-flight reads
// ensures the fixed 2-cycle memory pipeline can never overflow the output FIFO.
module dm_unloader #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DM_ADDR_WIDTH = 8,
  parameter int unsigned INST_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DM_ADDR_WIDTH-1:0]  base_addr,
  input  logic [DM_ADDR_WIDTH:0]    len,
  output logic                      busy,
  output logic                      done,
  output logic [INST_WIDTH-1:0]     dm_inst,
  output logic                      dm_rden,
  input  logic [DATA_WIDTH*2-1:0]   dm_rdata0,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH*2-1:0]   m_data,
  output logic                      m_last
);

  localparam int unsigned DW = DATA_WIDTH * 2;
  localparam int unsigned AW = DM_ADDR_WIDTH;
  localparam int unsigned LW = DM_ADDR_WIDTH + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              state_q;
  logic [AW-1:0]       addr_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       issued_q;
  logic [LW-1:0]       out_cnt_q;
  logic                iss_q;    // address on dm_inst this cycle
  logic                rden_q;   // read enable stage
  logic                wr_q;     // dm_rdata0 valid, push at end of cycle
  logic                busy_q;
  logic                done_q;
  logic [INST_WIDTH-1:0] inst_q;

  logic [DW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q;
  logic [PW-1:0]       rptr_q;
  logic [CW-1:0]       cnt_q;

  logic [1:0]          inflight;
  logic                credit_ok;
  logic                issue;
  logic                push;
  logic                pop;

  // Credit check, issue decision and output stream decode.
  always_comb begin
    inflight  = {1'b0, iss_q} + {1'b0, rden_q} + {1'b0, wr_q};
    credit_ok = ((CW+1)'(cnt_q) + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
    issue     = (state_q == StIssue) && credit_ok;
    push      = wr_q;
    m_valid   = (cnt_q != '0);
    pop       = m_valid && m_ready;
    m_data    = m_valid ? fifo_mem[rptr_q] : '0;
    m_last    = m_valid && (out_cnt_q == (len_q - LW'(1)));
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dm_inst = inst_q;
  assign dm_rden = rden_q;

  // Transfer FSM, address issue and read pipeline tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      out_cnt_q <= '0;
      iss_q     <= 1'b0;
      rden_q    <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      inst_q    <= '0;
    end else begin
      done_q <= 1'b0;
      iss_q  <= issue;
      rden_q <= iss_q;
      wr_q   <= rden_q;
      if (issue) begin
        inst_q   <= {{(INST_WIDTH-AW){1'b0}}, addr_q};
        addr_q   <= addr_q + AW'(1);
        issued_q <= issued_q + LW'(1);
      end
      if (pop) begin
        out_cnt_q <= out_cnt_q + LW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len != '0) begin
              state_q   <= StIssue;
              busy_q    <= 1'b1;
              addr_q    <= base_addr;
              len_q     <= len;
              issued_q  <= '0;
              out_cnt_q <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (issue && (issued_q == (len_q - LW'(1)))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && m_last) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr_q] <= dm_rdata0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dm_unloader.sv
// Self-checking bench for dm_unloader: memory model with the fixed 2-cycle read
// pipeline, scoreboard of expected words filled at start, popped on transfer.
module tb_dm_unloader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  len = '0;
  logic        busy;
  logic        done;
  logic [31:0] dm_inst;
  logic        dm_rden;
  logic [31:0] dm_rdata0 = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;

  dm_unloader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .dm_inst   (dm_inst),
    .dm_rden   (dm_rden),
    .dm_rdata0 (dm_rdata0),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mem [256];
  logic [7:0]  mem_addr_q = '0;

  logic [32:0] sb [$];   // {last, data}
  logic [7:0]  rd_addrs [$];
  int          rden_cnt = 0;
  int          pops = 0;
  int          first_valid = -1;
  logic        hold_pending = 1'b0;
  logic [32:0] hold_val = '0;

  logic        rdy_mode = 1'b0;   // 0: constant, 1: random
  logic        rdy_const = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: address captured in T, read on rden in T+1, data held from T+2.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_addr_q <= dm_inst[7:0];
    if (dm_rden) dm_rdata0 <= mem[mem_addr_q];
  end

  always @(posedge clk) begin
    #1;
    m_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_const;
  end

  // Monitor on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_rden) begin
        rden_cnt++;
        rd_addrs.push_back(mem_addr_q);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (hold_pending) check("hold_stable", {31'd0, m_valid, m_last, m_data},
                              {31'd0, 1'b1, hold_val});
      hold_pending = m_valid && !m_ready;
      hold_val = {m_last, m_data};
      if (m_valid && m_ready) begin
        pops++;
        if (sb.size() == 0) begin
          check("unexpected_word", {32'd0, m_data}, 64'hdead);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("data", {32'd0, m_data}, {32'd0, e[31:0]});
          check("last", {63'd0, m_last}, {63'd0, e[32]});
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic start_xfer(input logic [7:0] b, input logic [8:0] l, output int c0);
    for (int i = 0; i < int'(l); i++) begin
      logic [7:0] a;
      a = b + 8'(i);
      sb.push_back({(i == int'(l) - 1), mem[a]});
    end
    rden_cnt = 0;
    pops = 0;
    rd_addrs.delete();
    first_valid = -1;
    @(posedge clk);
    #2;
    start = 1'b1;
    base_addr = b;
    len = l;
    c0 = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit seen;
    seen = 0;
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        dc = cyc;
        break;
      end
    end
    if (!seen) check("timeout_done", 64'd0, 64'd1);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {59'd0, busy, done, dm_rden, m_valid, m_last, dm_inst},
          64'd0);
    check({tag, "_data"}, {32'd0, m_data}, 64'd0);
  endtask

  initial begin
    int c0;
    int dc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'hAAAA_0001;
    mem[8'h11] = 32'hBBBB_0002;
    mem[8'h12] = 32'hCCCC_0003;
    mem[8'h13] = 32'hDDDD_0004;

    // Reset
    #3;
    check_idle_outputs("reset_during");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_after");

    // Basic read with latency checks
    start_xfer(8'h10, 9'd4, c0);
    wait_done(50, dc);
    check("first_valid_cycle", 64'(first_valid - c0), 64'd5);
    check("done_cycle", 64'(dc - c0), 64'd9);
    check("basic_rden_cnt", 64'(rden_cnt), 64'd4);

    // Address wrap
    start_xfer(8'hFE, 9'd4, c0);
    wait_done(50, dc);
    check("wrap_cnt", 64'(rd_addrs.size()), 64'd4);
    if (rd_addrs.size() == 4) begin
      check("wrap_a0", 64'(rd_addrs[0]), 64'hFE);
      check("wrap_a1", 64'(rd_addrs[1]), 64'hFF);
      check("wrap_a2", 64'(rd_addrs[2]), 64'h00);
      check("wrap_a3", 64'(rd_addrs[3]), 64'h01);
    end

    // Backpressure: FIFO fills, reads stop
    rdy_const = 1'b0;
    start_xfer(8'h30, 9'd20, c0);
    repeat (30) @(negedge clk);
    check("bp_rden_stop", 64'(rden_cnt), 64'd8);
    check("bp_valid", {63'd0, m_valid}, 64'd1);
    check("bp_busy", {63'd0, busy}, 64'd1);
    rdy_const = 1'b1;
    wait_done(200, dc);
    check("bp_pops", 64'(pops), 64'd20);

    // Random ready
    rdy_mode = 1'b1;
    start_xfer(8'h70, 9'd20, c0);
    wait_done(400, dc);
    check("rand_pops", 64'(pops), 64'd20);
    rdy_mode = 1'b0;
    @(negedge clk);

    // len == 0
    start_xfer(8'h55, 9'd0, c0);
    wait_done(10, dc);
    check("len0_done_cycle", 64'(dc - c0), 64'd1);
    repeat (5) @(negedge clk);
    check("len0_rden", 64'(rden_cnt), 64'd0);

    // len == 256
    start_xfer(8'h00, 9'd256, c0);
    wait_done(600, dc);
    check("len256_pops", 64'(pops), 64'd256);
    check("len256_rden", 64'(rden_cnt), 64'd256);
    if (rd_addrs.size() == 256) check("len256_last_addr", 64'(rd_addrs[255]), 64'hFF);
    else check("len256_addr_cnt", 64'(rd_addrs.size()), 64'd256);

    // Reset mid-transfer
    start_xfer(8'h20, 9'd10, c0);
    begin
      bit reached;
      reached = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (pops >= 3) begin
          reached = 1;
          break;
        end
      end
      if (!reached) check("timeout_word3", 64'd0, 64'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset_after");
    start_xfer(8'h40, 9'd3, c0);
    wait_done(50, dc);
    check("post_reset_pops", 64'(pops), 64'd3);
    check("post_reset_addr0", 64'(rd_addrs.size() > 0 ? rd_addrs[0] : 8'h00), 64'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
